vrf_masked: RTL and testbench



---
 rtl/vrf_masked.sv | 215 +++++++++++++++++++++
 tb/tb_vrf_masked.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_masked.sv
// ============================================================================
// vrf_masked -- vector register file with per-lane write mask and a hardware
//               sweep-clear sequencer.
//
// NREGS registers of LANES lanes x LANE_W bits each (VW = LANES*LANE_W bits).
// Two independent combinational read ports, one write port with a per-lane
// write mask. A sweep-clear sequencer zeroes the whole file one register per
// clock so the controller can scrub vector state without a processor reset.
//
// Parameters:
//   NREGS   number of vector registers (>= 2)
//   ADDR_W  register index width, must equal $clog2(NREGS)
//   LANES   lanes per register
//   LANE_W  bits per lane
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset (clears file and sequencer)
//   vreg1     in   read address, port 1
//   vreg2     in   read address, port 2
//   vregw     in   write address
//   vdataw    in   write data, lane i = vdataw[i*LANE_W +: LANE_W]
//   vwmask    in   per-lane write enable
//   VRFWrite  in   write request
//   clr_req   in   start a sweep-clear (pulse or level; ignored while busy)
//   busy      out  sweep in progress (registered)
//   wr_drop   out  write request rejected this cycle because of a sweep
//   vdata1    out  read data, port 1 (0 for an index >= NREGS)
//   vdata2    out  read data, port 2 (0 for an index >= NREGS)
//
// Build option:
//   VRF_BYPASS_EN  when defined, an accepted write is forwarded to any read
//                  port addressing the same register in the same cycle, with
//                  the write mask applied (masked lanes from vdataw, others
//                  from storage). When undefined, reads show storage only.
// ============================================================================
module vrf_masked #(
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2,
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        vreg1,
    input  logic [ADDR_W-1:0]        vreg2,
    input  logic [ADDR_W-1:0]        vregw,
    input  logic [LANES*LANE_W-1:0]  vdataw,
    input  logic [LANES-1:0]         vwmask,
    input  logic                     VRFWrite,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop,
    output logic [LANES*LANE_W-1:0]  vdata1,
    output logic [LANES*LANE_W-1:0]  vdata2
);

    localparam int VW = LANES * LANE_W;

    // ------------------------------------------------------------------
    // Sweep sequencer state
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]   cnt_next;

    // ------------------------------------------------------------------
    // Storage and per-register control
    // ------------------------------------------------------------------
    logic [VW-1:0]       mem_reg [NREGS];

    logic                wr_en;     // write accepted this cycle
    logic [NREGS-1:0]    wr_hit;    // accepted write targets register k
    logic [NREGS-1:0]    clr_hit;   // sweep zeroes register k at this edge

    logic [VW-1:0]       rd1_store;
    logic [VW-1:0]       rd2_store;

    // busy is a decode of the state flop, so it is itself registered.
    assign busy    = (state_reg == SWEEP);
    assign wr_drop = VRFWrite & busy;
    assign wr_en   = VRFWrite & ~busy;

    // ------------------------------------------------------------------
    // Per-register decode. Only indices below NREGS get a decoder, so a
    // write to an out-of-range index matches nothing and is silently
    // ignored without needing a separate range compare.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
            assign wr_hit[gi]  = wr_en && (vregw == ADDR_W'(gi));
            assign clr_hit[gi] = busy && (cnt_reg == ADDR_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. clr_req is only looked at in IDLE, so a
    // request during a sweep neither restarts nor extends it.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                if (cnt_reg == ADDR_W'(NREGS - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file storage. Sweep clear takes priority over a write,
    // although the two never coincide because writes are blocked while
    // busy. Unmasked lanes hold their contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREGS; k++) begin
                mem_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (clr_hit[k]) begin
                    mem_reg[k] <= '0;
                end else if (wr_hit[k]) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (vwmask[l]) begin
                            mem_reg[k][l*LANE_W +: LANE_W] <= vdataw[l*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read muxes. An index with no matching register falls through to
    // the zero default.
    // ------------------------------------------------------------------
    always_comb begin
        rd1_store = '0;
        rd2_store = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (vreg1 == ADDR_W'(k)) begin
                rd1_store = mem_reg[k];
            end
            if (vreg2 == ADDR_W'(k)) begin
                rd2_store = mem_reg[k];
            end
        end
    end

`ifdef VRF_BYPASS_EN
    // ------------------------------------------------------------------
    // Write-to-read forwarding, lane by lane. wr_en already excludes
    // dropped writes; an out-of-range write index cannot equal an
    // in-range read index that returns storage, and if both are out of
    // range the forwarded lanes would still be wrong, so qualify with a
    // hit on a real register as well.
    // ------------------------------------------------------------------
    logic byp1;
    logic byp2;

    assign byp1 = wr_en && (|wr_hit) && (vregw == vreg1);
    assign byp2 = wr_en && (|wr_hit) && (vregw == vreg2);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_byp
            assign vdata1[gi*LANE_W +: LANE_W] = (byp1 && vwmask[gi])
                                               ? vdataw[gi*LANE_W +: LANE_W]
                                               : rd1_store[gi*LANE_W +: LANE_W];
            assign vdata2[gi*LANE_W +: LANE_W] = (byp2 && vwmask[gi])
                                               ? vdataw[gi*LANE_W +: LANE_W]
                                               : rd2_store[gi*LANE_W +: LANE_W];
        end
    endgenerate
`else
    assign vdata1 = rd1_store;
    assign vdata2 = rd2_store;
`endif

endmodule

// File: tb/tb_vrf_masked.sv
// ============================================================================
// tb_vrf_masked -- directed self-checking bench for vrf_masked
// (NREGS=4, LANES=4, LANE_W=8). Inputs change 1 ns after the rising edge;
// outputs are sampled before the following edge.
// ============================================================================
module tb_vrf_masked;

    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int VW     = LANES * LANE_W;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] vreg1;
    logic [ADDR_W-1:0] vreg2;
    logic [ADDR_W-1:0] vregw;
    logic [VW-1:0]     vdataw;
    logic [LANES-1:0]  vwmask;
    logic              VRFWrite;
    logic              clr_req;
    logic              busy;
    logic              wr_drop;
    logic [VW-1:0]     vdata1;
    logic [VW-1:0]     vdata2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [VW-1:0] fill_vals [NREGS];

    vrf_masked #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .vreg1    (vreg1),
        .vreg2    (vreg2),
        .vregw    (vregw),
        .vdataw   (vdataw),
        .vwmask   (vwmask),
        .VRFWrite (VRFWrite),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .vdata1   (vdata1),
        .vdata2   (vdata2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input int idx, input logic [VW-1:0] data, input logic [LANES-1:0] mask);
        vregw    = idx[ADDR_W-1:0];
        vdataw   = data;
        vwmask   = mask;
        VRFWrite = 1'b1;
        tick();
        VRFWrite = 1'b0;
    endtask

    task automatic rd1(input int idx, output logic [VW-1:0] d);
        vreg1 = idx[ADDR_W-1:0];
        #1;
        d = vdata1;
    endtask

    task automatic rd2(input int idx, output logic [VW-1:0] d);
        vreg2 = idx[ADDR_W-1:0];
        #1;
        d = vdata2;
    endtask

    task automatic fill_all();
        for (int k = 0; k < NREGS; k++) begin
            do_write(k, fill_vals[k], 4'b1111);
        end
    endtask

    initial begin
        logic [VW-1:0] d;
        int            n;

        fill_vals[0] = 32'h0A0A_0A0A;
        fill_vals[1] = 32'h1B1B_1B1B;
        fill_vals[2] = 32'h2C2C_2C2C;
        fill_vals[3] = 32'h3D3D_3D3D;

        reset    = 1'b0;
        vreg1    = '0;
        vreg2    = '0;
        vregw    = '0;
        vdataw   = '0;
        vwmask   = '0;
        VRFWrite = 1'b0;
        clr_req  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy",   {31'b0, busy},    32'h0);
        check("rst_wrdrop", {31'b0, wr_drop}, 32'h0);
        check("rst_vdata1", vdata1, 32'h0);
        check("rst_vdata2", vdata2, 32'h0);
        reset = 1'b1;
        tick();

        // ---------------- full-mask write ----------------
        do_write(2, 32'hAABB_CCDD, 4'b1111);
        rd1(2, d);
        check("wr_reg2", d, 32'hAABB_CCDD);
        for (int k = 0; k < NREGS; k++) begin
            if (k != 2) begin
                rd2(k, d);
                check($sformatf("untouched_reg%0d", k), d, 32'h0);
            end
        end

        // ---------------- masked write ----------------
        do_write(1, 32'h1122_3344, 4'b1111);
        vregw    = 2'd1;
        vdataw   = 32'hFFFF_FFFF;
        vwmask   = 4'b0101;
        VRFWrite = 1'b1;
        vreg1    = 2'd1;
        #1;
`ifdef VRF_BYPASS_EN
        check("bypass_same_cycle", vdata1, 32'h11FF_33FF);
`else
        check("no_bypass_same_cycle", vdata1, 32'h1122_3344);
`endif
        tick();
        VRFWrite = 1'b0;
        rd1(1, d);
        check("masked_reg1", d, 32'h11FF_33FF);
        // Zero mask: accepted, nothing changes.
        do_write(1, 32'h0000_0000, 4'b0000);
        rd1(1, d);
        check("zero_mask_reg1", d, 32'h11FF_33FF);

        // ---------------- sweep clear ----------------
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("sweep_start_busy", {31'b0, busy}, 32'h1);
        rd1(0, d);
        check("sweep_start_reg0", d, fill_vals[0]);
        for (int c = 0; c < NREGS; c++) begin
            tick();
            rd1(c, d);
            check($sformatf("sweep_reg%0d_zero", c), d, 32'h0);
            if (c < NREGS - 1) begin
                rd2(c + 1, d);
                check($sformatf("sweep_reg%0d_kept", c + 1), d, fill_vals[c + 1]);
            end
            check($sformatf("sweep_busy_after_edge%0d", c + 1), {31'b0, busy},
                  (c < NREGS - 1) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < NREGS; k++) begin
            rd1(k, d);
            check($sformatf("post_sweep_reg%0d", k), d, 32'h0);
        end

        // ---------------- dropped write and clr_req re-pulse ----------------
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            if (n == 0) begin
                vregw    = 2'd3;
                vdataw   = 32'h1234_5678;
                vwmask   = 4'b1111;
                VRFWrite = 1'b1;
                #1;
                check("wr_drop_during_sweep", {31'b0, wr_drop}, 32'h1);
            end
            if (n == 2) begin
                clr_req = 1'b1;
            end
            tick();
            VRFWrite = 1'b0;
            clr_req  = 1'b0;
            n++;
        end
        check("busy_cycles_with_repulse", n, NREGS);
        check("wr_drop_idle", {31'b0, wr_drop}, 32'h0);
        rd1(3, d);
        check("dropped_reg3", d, 32'h0);
        do_write(2, 32'hCAFE_F00D, 4'b1111);
        rd1(2, d);
        check("first_write_after_sweep", d, 32'hCAFE_F00D);

        // ---------------- clr_req and write in the same IDLE cycle ----------------
        vregw    = 2'd0;
        vdataw   = 32'hDEAD_BEEF;
        vwmask   = 4'b1111;
        VRFWrite = 1'b1;
        clr_req  = 1'b1;
        #1;
        check("same_cycle_wr_drop", {31'b0, wr_drop}, 32'h0);
        tick();
        VRFWrite = 1'b0;
        clr_req  = 1'b0;
        rd1(0, d);
        check("same_cycle_write_landed", d, 32'hDEAD_BEEF);
        check("same_cycle_busy", {31'b0, busy}, 32'h1);
        tick();
        rd1(0, d);
        check("same_cycle_reg0_cleared", d, 32'h0);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("same_cycle_sweep_done", {31'b0, busy}, 32'h0);

        // ---------------- reset mid-sweep ----------------
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midsweep_rst_busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < NREGS; k++) begin
            rd1(k, d);
            check($sformatf("midsweep_rst_reg%0d", k), d, 32'h0);
        end
        tick();
        reset = 1'b1;
        tick();
        do_write(1, 32'h55AA_55AA, 4'b1111);
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        rd2(1, d);
        check("post_rst_write", d, 32'h55AA_55AA);
        rd2(2, d);
        check("post_rst_reg2", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
